global_history_manager: RTL and testbench
=========================================

Name: global_history_manager

Overview:
- Maintains the 12-bit global path history that indexes the global 2-bit counter table; it is the producer of PathHistory and the consumer of resolved branch outcomes.
- Speculatively shifts in each predicted direction and checkpoints every in-flight branch in an in-order queue.
- On resolution it commits the actual outcome. On a mispredict it repairs the speculative history and squashes all younger in-flight branches.
- Sits between fetch/predict and the branch resolution stage.

Parameters:
HIST_W, 12, history width (matches the 4096-entry global table index)
DEPTH, 8, maximum in-flight unresolved branches (checkpoint queue entries)
CNT_W, $clog2(DEPTH+1), width of inflight_count

Ports:
clock  input  1  clock
reset  input  1  asynchronous, active-high reset
predict_valid  input  1  new branch predicted this cycle
predict_taken  input  1  predicted direction
predict_ready  output  1  queue can accept a branch: !full, combinational from registered count
resolve_valid  input  1  oldest in-flight branch resolved this cycle
resolve_taken  input  1  actual direction of oldest branch
path_history  output  HIST_W  speculative history (table index), registered
commit_history  output  HIST_W  architectural history of resolved branches, registered
flush  output  1  one-cycle registered pulse after a mispredict
inflight_count  output  CNT_W  entries in queue
underflow_err  output  1  sticky: resolve_valid seen with empty queue

Behaviour:
- Reset (asynchronous, active-high; clock is clock):
  - path_history = 0, commit_history = 0, flush = 0, underflow_err = 0, inflight_count = 0.
  - Queue pointers = 0; queue contents are don't-care.
  - Reset mid-operation discards all in-flight entries immediately.
- Queue: circular FIFO of DEPTH entries, each holding the predicted bit. Head and tail pointers wrap modulo DEPTH.
- Push (predict_valid && predict_ready):
  - Write predict_taken at tail.
  - path_history <= {path_history[HIST_W-2:0], predict_taken} on the next edge.
- predict_valid while full is ignored: no push, no history change. Upstream must hold the request.
- Push and pop in the same cycle when full: the push is still blocked, because predict_ready is not a function of resolve_valid.
- Pop (resolve_valid && count != 0):
  - Read the head entry.
  - commit_history <= {commit_history[HIST_W-2:0], resolve_taken}.
  - Correct (head bit == resolve_taken): pop head; count decrements unless a push occurs in the same cycle.
  - Mispredict (head bit != resolve_taken):
    - path_history <= {commit_history[HIST_W-2:0], resolve_taken}.
    - Queue flushed: head = tail, count = 0.
    - flush = 1 on the following cycle only.
    - A push in the same cycle is discarded; mispredict wins.
- resolve_valid with count == 0: ignored; underflow_err <= 1, held until reset.
- Latency: all outputs update on the clock edge after the causing input; there are no combinational paths from inputs to outputs.
- Invariant: whenever inflight_count == 0 and no push is pending, path_history == commit_history.
- Back-to-back mispredicts on consecutive cycles are legal. The second resolve sees an empty queue (underflow) unless a new push intervened.
- Histories shift with the oldest bit dropped; there is no saturation.

Test Plan:
- Reset, then 3 pushes with taken = 1, 0, 1 -> path_history = 0x005, commit_history = 0x000, inflight_count = 3, predict_ready = 1.
- From that state, 3 correct resolves (1, 0, 1) -> commit_history = 0x005 = path_history, inflight_count = 0, flush never asserted.
- Push 8 taken branches -> inflight_count = 8, predict_ready = 0. A 9th predict_valid is ignored; path_history = 0x0FF, unchanged by the 9th.
- From 0x0FF with 8 in flight, resolve oldest with taken = 0 -> next edge: path_history = 0x000, commit_history = 0x000, inflight_count = 0, flush = 1 for exactly one cycle.
- Mispredicting resolve in the same cycle as predict_valid = 1 -> the push is dropped: inflight_count = 0, path_history = {commit[10:0], actual}.
- resolve_valid with an empty queue -> underflow_err = 1 and sticky, histories unchanged. Asserting reset mid-burst clears all outputs to 0 asynchronously.

Source files
------------

// File: rtl/global_history_manager.sv
// Speculative global path history with an in-order checkpoint queue of predicted
// directions; commits resolved outcomes and repairs history on a mispredict.
module global_history_manager #(
    parameter int HIST_W = 12,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              predict_valid,
    input  logic              predict_taken,
    output logic              predict_ready,
    input  logic              resolve_valid,
    input  logic              resolve_taken,
    output logic [HIST_W-1:0] path_history,
    output logic [HIST_W-1:0] commit_history,
    output logic              flush,
    output logic [CNT_W-1:0]  inflight_count,
    output logic              underflow_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DEPTH-1:0] queueBits;
    logic [PTR_W-1:0] headPtr;
    logic [PTR_W-1:0] tailPtr;
    logic             pushEn;
    logic             popEn;
    logic             mispredict;
    logic             acceptPush;
    logic [PTR_W-1:0] headNext;
    logic [PTR_W-1:0] tailNext;

    // Readiness depends only on the registered count, so a same-cycle pop never unblocks a full queue
    assign predict_ready = (inflight_count != FULL_CNT);
    assign pushEn        = predict_valid && predict_ready;
    assign popEn         = resolve_valid && (inflight_count != '0);
    assign mispredict    = popEn && (queueBits[headPtr] != resolve_taken);
    assign acceptPush    = pushEn && !mispredict;
    assign headNext      = (headPtr == LAST_PTR) ? '0 : headPtr + PTR_W'(1);
    assign tailNext      = (tailPtr == LAST_PTR) ? '0 : tailPtr + PTR_W'(1);

    always_ff @(posedge clock) begin
        if (acceptPush) begin
            queueBits[tailPtr] <= predict_taken;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            headPtr        <= '0;
            tailPtr        <= '0;
            inflight_count <= '0;
            path_history   <= '0;
            commit_history <= '0;
            flush          <= 1'b0;
            underflow_err  <= 1'b0;
        end else begin
            flush <= mispredict;
            if (resolve_valid && (inflight_count == '0)) begin
                underflow_err <= 1'b1;
            end
            if (popEn) begin
                commit_history <= {commit_history[HIST_W-2:0], resolve_taken};
            end
            // A mispredict rebuilds speculation from the architectural history and drops every younger entry
            if (mispredict) begin
                path_history   <= {commit_history[HIST_W-2:0], resolve_taken};
                headPtr        <= tailPtr;
                inflight_count <= '0;
            end else begin
                if (acceptPush) begin
                    tailPtr      <= tailNext;
                    path_history <= {path_history[HIST_W-2:0], predict_taken};
                end
                if (popEn) begin
                    headPtr <= headNext;
                end
                if (acceptPush && !popEn) begin
                    inflight_count <= inflight_count + CNT_W'(1);
                end else if (!acceptPush && popEn) begin
                    inflight_count <= inflight_count - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_global_history_manager.sv
// Directed self-checking bench for global_history_manager using immediate assertions.
module tb_global_history_manager;

    localparam int HIST_W = 12;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clock;
    logic              reset;
    logic              predictValid;
    logic              predictTaken;
    logic              predictReady;
    logic              resolveValid;
    logic              resolveTaken;
    logic [HIST_W-1:0] pathHistory;
    logic [HIST_W-1:0] commitHistory;
    logic              flush;
    logic [CNT_W-1:0]  inflightCount;
    logic              underflowErr;

    int checkCount = 0;
    int passCount  = 0;

    global_history_manager #(.HIST_W(HIST_W), .DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .predict_valid  (predictValid),
        .predict_taken  (predictTaken),
        .predict_ready  (predictReady),
        .resolve_valid  (resolveValid),
        .resolve_taken  (resolveTaken),
        .path_history   (pathHistory),
        .commit_history (commitHistory),
        .flush          (flush),
        .inflight_count (inflightCount),
        .underflow_err  (underflowErr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    // One clock of stimulus; outputs are sampled 1 time unit after the edge
    task automatic applyStimulus(input logic pv, input logic pt, input logic rv, input logic rt);
        predictValid = pv;
        predictTaken = pt;
        resolveValid = rv;
        resolveTaken = rt;
        @(posedge clock);
        #1;
        predictValid = 1'b0;
        predictTaken = 1'b0;
        resolveValid = 1'b0;
        resolveTaken = 1'b0;
    endtask

    task automatic checkState(input string tag, input logic [HIST_W-1:0] path, input logic [HIST_W-1:0] commit,
                              input logic [CNT_W-1:0] cnt, input logic rdy, input logic fl, input logic uf);
        checkOutput({tag, ".path"},   32'(pathHistory),   32'(path));
        checkOutput({tag, ".commit"}, 32'(commitHistory), 32'(commit));
        checkOutput({tag, ".count"},  32'(inflightCount), 32'(cnt));
        checkOutput({tag, ".ready"},  32'(predictReady),  32'(rdy));
        checkOutput({tag, ".flush"},  32'(flush),         32'(fl));
        checkOutput({tag, ".uflow"},  32'(underflowErr),  32'(uf));
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        predictValid = 1'b0;
        predictTaken = 1'b0;
        resolveValid = 1'b0;
        resolveTaken = 1'b0;
        #12;
        checkState("reset", 12'h000, 12'h000, 4'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0);
        checkState("push3", 12'h005, 12'h000, 4'd3, 1'b1, 1'b0, 1'b0);

        applyStimulus(0, 0, 1, 1);
        checkState("res1", 12'h005, 12'h001, 4'd2, 1'b1, 1'b0, 1'b0);
        applyStimulus(0, 0, 1, 0);
        checkState("res2", 12'h005, 12'h002, 4'd1, 1'b1, 1'b0, 1'b0);
        applyStimulus(0, 0, 1, 1);
        checkState("res3", 12'h005, 12'h005, 4'd0, 1'b1, 1'b0, 1'b0);

        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(1, 1, 0, 0);
        checkState("full", 12'h0FF, 12'h000, 4'd8, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, 0, 0, 0);
        checkState("push9", 12'h0FF, 12'h000, 4'd8, 1'b0, 1'b0, 1'b0);

        // Oldest was predicted taken; resolving not-taken repairs from commit history
        applyStimulus(0, 0, 1, 0);
        checkState("mispred", 12'h000, 12'h000, 4'd0, 1'b1, 1'b1, 1'b0);
        applyStimulus(0, 0, 0, 0);
        checkState("flushEnd", 12'h000, 12'h000, 4'd0, 1'b1, 1'b0, 1'b0);

        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 0, 1, 1);
        checkState("preMis2", 12'h003, 12'h001, 4'd1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1, 1, 1, 0);
        checkState("misPush", 12'h002, 12'h002, 4'd0, 1'b1, 1'b1, 1'b0);

        applyStimulus(0, 0, 1, 1);
        checkState("underflow", 12'h002, 12'h002, 4'd0, 1'b1, 1'b0, 1'b1);
        applyStimulus(0, 0, 0, 0);
        checkState("sticky", 12'h002, 12'h002, 4'd0, 1'b1, 1'b0, 1'b1);

        applyStimulus(1, 1, 0, 0);
        predictValid = 1'b1;
        predictTaken = 1'b1;
        @(posedge clock);
        #1;
        checkState("burst", 12'h00B, 12'h002, 4'd2, 1'b1, 1'b0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        checkState("asyncRst", 12'h000, 12'h000, 4'd0, 1'b1, 1'b0, 1'b0);
        predictValid = 1'b0;
        predictTaken = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(1, 0, 0, 0);
        checkState("postRst", 12'h000, 12'h000, 4'd1, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
